// File: rtl/perceptron_pkg.sv
// Shared constants and FSM encoding for the perceptron trainer and its classifier.
package perceptron_pkg;

  localparam int unsigned NUM_W       = 16;
  localparam int unsigned W_WIDTH     = 8;
  localparam int unsigned IDX_WIDTH   = 4;
  localparam logic [7:0]  INIT_WEIGHT = 8'h80;
  localparam logic [7:0]  LR_DEFAULT  = 8'h10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/weight_sat_update.sv
// Combinational weight step: add or subtract the learning rate, clamped to the weight range.
module weight_sat_update #(
  parameter int unsigned W_WIDTH = 8
) (
  input  logic [W_WIDTH-1:0] weight_i,
  input  logic [W_WIDTH-1:0] lr_i,
  input  logic               inc_i,
  output logic [W_WIDTH-1:0] result_o
);

  logic [W_WIDTH:0] sum;
  logic [W_WIDTH:0] diff;

  always_comb begin
    sum  = {1'b0, weight_i} + {1'b0, lr_i};
    diff = {1'b0, weight_i} - {1'b0, lr_i};
    if (inc_i) begin
      result_o = sum[W_WIDTH] ? '1 : sum[W_WIDTH-1:0];
    end else begin
      // The extra bit of the difference is the borrow out of the subtraction.
      result_o = diff[W_WIDTH] ? '0 : diff[W_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/perceptron_trainer.sv
// One perceptron training step per start: scans the latched sample bits and writes updated weights.
module perceptron_trainer #(
  parameter int unsigned NUM_W   = perceptron_pkg::NUM_W,
  parameter int unsigned W_WIDTH = perceptron_pkg::W_WIDTH,
  parameter logic [7:0]  LR      = perceptron_pkg::LR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         inputs1,
  input  logic [7:0]         inputs2,
  input  logic               target,
  input  logic               pred,
  output logic               busy,
  output logic               done,
  output logic               w_valid,
  input  logic               w_ready,
  output logic [3:0]         w_addr,
  output logic [W_WIDTH-1:0] w_data,
  output logic [7:0]         err_count
);

  import perceptron_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(NUM_W - 1);

  state_e               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [7:0]           err_q, err_d;
  logic [NUM_W-1:0]     sample_q;
  logic                 target_q;
  logic [3:0]           waddr_q;
  logic [W_WIDTH-1:0]   wdata_q;
  logic [W_WIDTH-1:0]   weights_q [NUM_W];
  logic [W_WIDTH-1:0]   new_weight;
  logic                 load;
  logic                 wr_load;
  logic                 wr_commit;
  logic                 last;

  // Only mismatched steps reach SCAN, so the latched target alone gives the update direction.
  weight_sat_update #(.W_WIDTH(W_WIDTH)) u_update (
    .weight_i (weights_q[idx_q]),
    .lr_i     (W_WIDTH'(LR)),
    .inc_i    (target_q),
    .result_o (new_weight)
  );

  assign last = (idx_q == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    load      = 1'b0;
    wr_load   = 1'b0;
    wr_commit = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load  = 1'b1;
          idx_d = '0;
          if (pred == target) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SCAN;
            if (err_q != '1) err_d = err_q + 8'd1;
          end
        end
      end
      ST_SCAN: begin
        if (sample_q[idx_q]) begin
          wr_load = 1'b1;
          state_d = ST_WRITE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = last ? ST_DONE : ST_SCAN;
        end
      end
      ST_WRITE: begin
        if (w_ready) begin
          wr_commit = 1'b1;
          idx_d     = idx_q + 4'd1;
          state_d   = last ? ST_DONE : ST_SCAN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '0;
      target_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      for (int unsigned i = 0; i < NUM_W; i++) weights_q[i] <= W_WIDTH'(INIT_WEIGHT);
    end else begin
      if (load) begin
        sample_q <= NUM_W'({inputs2, inputs1});
        target_q <= target;
      end
      if (wr_load) begin
        waddr_q <= idx_q;
        wdata_q <= new_weight;
      end
      if (wr_commit) weights_q[waddr_q] <= wdata_q;
    end
  end

  assign busy      = (state_q == ST_SCAN) || (state_q == ST_WRITE);
  assign done      = (state_q == ST_DONE);
  assign w_valid   = (state_q == ST_WRITE);
  assign w_addr    = waddr_q;
  assign w_data    = wdata_q;
  assign err_count = err_q;

endmodule
